// File: rtl/mem_ram.sv
// -----------------------------------------------------------------------------
// mem_ram
//
// Byte-addressed single-port RAM model placed directly behind the memory
// controller. It is the main memory for simulation and FPGA builds.
//
// Request protocol:
//   - The controller holds valid_i high until it sees the done pulse.
//   - The request is captured on the first rising edge with valid_i = 1 while
//     idle. Later input changes are ignored.
//   - Exactly LATENCY edges after that capture, the access is performed and
//     valid_o pulses high for one cycle.
//   - The RAM then waits for valid_i to be seen low before it accepts another
//     request, so a request held across the pulse is serviced only once.
//
// Parameters:
//   BITSIZE    data word width in bits (must be 32)
//   MEM_SIZE   memory size in bytes (multiple of 4)
//   BASE_ADDR  byte address mapped to memory byte 0
//   LATENCY    edges from request capture to done pulse (>= 1)
//
// Ports:
//   clk           clock
//   resetn_i      asynchronous, active-low reset
//   addr_i        byte address
//   data_i        write data, right-aligned
//   write_i       1 = write, 0 = read
//   write_size_i  00 byte, 01 halfword, 10/11 word
//   valid_i       request valid
//   data_o        registered read data; holds until the next read completes
//   valid_o       registered one-cycle done pulse
// -----------------------------------------------------------------------------
module mem_ram #(
    parameter int          BITSIZE   = 32,
    parameter int          MEM_SIZE  = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic [31:0]        addr_i,
    input  logic [BITSIZE-1:0] data_i,
    input  logic               write_i,
    input  logic [1:0]         write_size_i,
    input  logic               valid_i,
    output logic [BITSIZE-1:0] data_o,
    output logic               valid_o
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Request fields captured at acceptance.
    logic [31:0]        addr_q;
    logic [BITSIZE-1:0] wdata_q;
    logic               write_q;
    logic [1:0]         size_q;

    logic accept;   // capture the request on this edge
    logic access;   // perform the access and raise valid_o on this edge

    // Address decode and write lane steering.
    logic [31:0]        off;
    logic               in_range;
    logic [AW-1:0]      word_idx;
    logic [3:0]         be;
    logic [BITSIZE-1:0] lane_data;
    logic [BITSIZE-1:0] rd_word;

    logic [7:0] mem [MEM_SIZE];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;

        case (state)
            IDLE: begin
                if (valid_i) begin
                    accept     = 1'b1;
                    cnt_next   = CW'(LATENCY - 1);
                    state_next = BUSY;
                end
            end

            // The counter is loaded with LATENCY-1 and the access fires when
            // it reads zero. The done pulse therefore rises exactly LATENCY
            // edges after acceptance. With LATENCY = 1 the counter loads zero,
            // so the very next edge completes the request and enters DONE.
            BUSY: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end

            DONE: begin
                state_next = RELEASE;
            end

            // Wait for the controller to drop valid_i. This stops a request
            // held across the done pulse from being accepted a second time.
            RELEASE: begin
                if (!valid_i) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    always_comb begin
        off      = addr_q - BASE_ADDR;
        in_range = (off < 32'(MEM_SIZE));
        word_idx = {off[AW-1:2], 2'b00};

        // Narrow writes replicate the data across the lanes. The byte enables
        // then pick the lane(s) that match the low offset bits.
        case (size_q)
            2'b00: begin
                be        = 4'b0001 << off[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                lane_data = wdata_q;
            end
        endcase

        // Little-endian: the lowest address lands in the least significant byte.
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            rd_word[8*i +: 8] = mem[word_idx + AW'(i)];
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            valid_o <= access;

            if (accept) begin
                addr_q  <= addr_i;
                wdata_q <= data_i;
                write_q <= write_i;
                size_q  <= write_size_i;
            end

            // Only reads update data_o. An out-of-range read returns zero.
            if (access && !write_q) begin
                data_o <= in_range ? rd_word : '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset. Clearing it would turn the RAM into a
    // huge register bank. Reset instead returns the FSM to IDLE, so access
    // stays low and any pending write is simply never issued.
    always_ff @(posedge clk) begin
        if (access && write_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx + AW'(i)] <= lane_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ram.sv
// -----------------------------------------------------------------------------
// tb_mem_ram
//
// Three mem_ram instances share one clock, with LATENCY = 2, 4 and 1.
// A byte-array reference model per instance holds the expected contents.
// Each request checks:
//   - the acceptance-to-done latency,
//   - the one-cycle pulse width,
//   - read data against the model,
//   - data_o holding across writes and idle cycles.
// -----------------------------------------------------------------------------
module tb_mem_ram;

    localparam int NU   = 3;
    localparam int MEMB = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [NU];
    logic [31:0] addr [NU];
    logic [31:0] wdat [NU];
    logic [31:0] dout [NU];
    logic        wr   [NU];
    logic        vin  [NU];
    logic        vout [NU];
    logic [1:0]  sz   [NU];

    for (genvar g = 0; g < NU; g++) begin : g_dut
        mem_ram #(
            .BITSIZE  (32),
            .MEM_SIZE (MEMB),
            .BASE_ADDR(32'h0),
            .LATENCY  ((g == 0) ? 2 : ((g == 1) ? 4 : 1))
        ) u_dut (
            .clk         (clk),
            .resetn_i    (rstn[g]),
            .addr_i      (addr[g]),
            .data_i      (wdat[g]),
            .write_i     (wr[g]),
            .write_size_i(sz[g]),
            .valid_i     (vin[g]),
            .data_o      (dout[g]),
            .valid_o     (vout[g])
        );
    end

    int          lat_of [NU] = '{2, 4, 1};
    logic [7:0]  mdl    [NU][MEMB];
    logic [31:0] last_rd[NU];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference model: plain byte array, base address 0.
    function automatic logic [31:0] model_read(input int u, input logic [31:0] a);
        int b;
        if (a >= 32'(MEMB)) return 32'h0;
        b = int'(a & ~32'd3);
        return {mdl[u][b+3], mdl[u][b+2], mdl[u][b+1], mdl[u][b]};
    endfunction

    function automatic void model_write(input int u, input logic [1:0] s,
                                        input logic [31:0] a, input logic [31:0] d);
        int b;
        if (a >= 32'(MEMB)) return;
        case (s)
            2'b00: mdl[u][int'(a)] = d[7:0];
            2'b01: begin
                b = int'(a & ~32'd1);
                mdl[u][b]   = d[7:0];
                mdl[u][b+1] = d[15:8];
            end
            default: begin
                b = int'(a & ~32'd3);
                for (int i = 0; i < 4; i++) mdl[u][b+i] = d[8*i +: 8];
            end
        endcase
    endfunction

    // Issue one request. Call at #1 after a rising edge with the DUT idle.
    // hold = 0: drop valid_i right after the done pulse.
    // hold > 0: keep valid_i high for that many more cycles, then drop it for one edge.
    task automatic do_req(input int u, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d, input int hold);
        int          n;
        logic [31:0] exp;
        logic [31:0] prev;
        prev = last_rd[u];
        exp  = w ? prev : model_read(u, a);
        if (w) model_write(u, s, a, d);
        else   last_rd[u] = exp;

        addr[u] = a; wdat[u] = d; wr[u] = w; sz[u] = s; vin[u] = 1'b1;
        @(posedge clk); #1;                       // acceptance edge
        check("no_early_done", 32'(vout[u]), 32'd0);
        check("hold_before_done", dout[u], prev);

        // Later input changes must be ignored.
        addr[u] = $urandom; wdat[u] = $urandom; wr[u] = ~w; sz[u] = 2'($urandom_range(0, 3));

        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (vout[u]) break;
        end
        check("latency", 32'(n), 32'(lat_of[u]));
        check(w ? "data_o_after_write" : "read_data", dout[u], exp);

        if (hold == 0) begin
            vin[u] = 1'b0;
            @(posedge clk); #1;
            check("pulse_width", 32'(vout[u]), 32'd0);
            check("data_hold", dout[u], exp);
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("no_repeat_pulse", 32'(vout[u]), 32'd0);
            end
            vin[u] = 1'b0;
            @(posedge clk); #1;
            check("no_pulse_release", 32'(vout[u]), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int u = 0; u < NU; u++) begin
            rstn[u] = 1'b0; vin[u] = 1'b0; wr[u] = 1'b0; sz[u] = 2'b00;
            addr[u] = '0; wdat[u] = '0; last_rd[u] = '0;
        end
        #12;
        for (int u = 0; u < NU; u++) begin
            check("reset_valid_o", 32'(vout[u]), 32'd0);
            check("reset_data_o", dout[u], 32'd0);
        end
        @(negedge clk);
        for (int u = 0; u < NU; u++) rstn[u] = 1'b1;
        @(posedge clk); #1;

        // Preload every word of every instance.
        for (int u = 0; u < NU; u++)
            for (int i = 0; i < MEMB / 4; i++)
                do_req(u, 1'b1, 2'b10, 32'(i * 4), $urandom, 0);

        // Word write then read.
        do_req(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0);
        do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, 0);
        check("deadbeef", last_rd[0], 32'hDEADBEEF);

        // Sub-word writes.
        do_req(0, 1'b1, 2'b10, 32'h20, 32'h11223344, 0);
        do_req(0, 1'b1, 2'b00, 32'h21, 32'h000000AA, 0);
        do_req(0, 1'b0, 2'b10, 32'h20, 32'h0, 0);
        check("byte_write", last_rd[0], 32'h1122AA44);
        do_req(0, 1'b1, 2'b01, 32'h23, 32'h0000BBCC, 0);
        do_req(0, 1'b0, 2'b10, 32'h20, 32'h0, 0);
        check("half_write", last_rd[0], 32'hBBCCAA44);

        // Held request, then re-acceptance after one low edge.
        do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, 5);
        do_req(0, 1'b0, 2'b10, 32'h20, 32'h0, 0);

        // Out of range.
        do_req(0, 1'b0, 2'b10, 32'h3FC, 32'h0, 0);
        do_req(0, 1'b1, 2'b10, 32'h400, 32'h12345678, 0);
        do_req(0, 1'b0, 2'b10, 32'h400, 32'h0, 0);
        check("oor_read_zero", last_rd[0], 32'h0);
        do_req(0, 1'b0, 2'b10, 32'h3FC, 32'h0, 0);

        // Reset during BUSY, LATENCY = 4.
        do_req(1, 1'b1, 2'b10, 32'h40, 32'h0BADC0DE, 0);
        do_req(1, 1'b0, 2'b10, 32'h40, 32'h0, 0);
        addr[1] = 32'h40; wdat[1] = 32'hCAFEF00D; wr[1] = 1'b1; sz[1] = 2'b10; vin[1] = 1'b1;
        @(posedge clk);                            // acceptance
        @(posedge clk);
        @(posedge clk); #1;
        rstn[1] = 1'b0; vin[1] = 1'b0;
        #1;
        check("rst_mid_valid_o", 32'(vout[1]), 32'd0);
        check("rst_mid_data_o", dout[1], 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn[1] = 1'b1;
        last_rd[1] = 32'h0;
        @(posedge clk); #1;
        check("rst_no_pulse", 32'(vout[1]), 32'd0);
        do_req(1, 1'b0, 2'b10, 32'h40, 32'h0, 0);
        check("write_dropped", last_rd[1], 32'h0BADC0DE);

        // LATENCY = 1 sweep of reads.
        for (int i = 0; i < 20; i++)
            do_req(2, 1'b0, 2'b10, 32'($urandom_range(0, MEMB - 1)), 32'h0, 1);

        // Random mix on all instances, including out-of-range addresses.
        for (int i = 0; i < 240; i++) begin
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, MEMB + 255));
            do_req(i % NU, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   a, $urandom, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
